// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and boot image for the instruction memory.
// Boot table entries are 16 bits; the user resizes them.
package imem_pkg;

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  localparam int unsigned BOOT_TBL_LEN = 8;

  localparam logic [15:0] BOOT_TBL [BOOT_TBL_LEN] = '{
    16'd1, 16'd6, 16'd4, 16'd1,
    16'd4, 16'd6, 16'd1, 16'd6
  };

  function automatic logic [15:0] boot_word(
    input int unsigned idx
  );
    logic [15:0] w;
    w = '0;
    if (idx < BOOT_TBL_LEN)
      w = BOOT_TBL[idx[2:0]];
    return w;
  endfunction

endpackage

// File: rtl/imem_boot_seq.sv
// Boot sequencer: walks every address once after start,
// writing the boot image then zeros, then flags ready.
module imem_boot_seq
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned BOOT_LEN = 8
) (
  input  logic              clk,
  input  logic              start,
  output logic              boot_we,
  output logic [ADDR_W-1:0] boot_addr,
  output logic [DATA_W-1:0] boot_data,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr_nx;

  // State and pointer registers; start restarts the boot walk.
  always_ff @(posedge clk) begin
    if (start) begin
      state     <= BOOT;
      boot_addr <= '0;
    end else begin
      state     <= state_nx;
      boot_addr <= addr_nx;
    end
  end

  // Next state: step the pointer, leave BOOT after the last word.
  always_comb begin
    state_nx = state;
    addr_nx  = boot_addr;
    boot_we  = 1'b0;
    ready    = 1'b0;
    unique case (state)
      BOOT: begin
        boot_we = ~start;
        if (boot_addr == LAST)
          state_nx = RUN;
        else
          addr_nx = boot_addr + ADDR_W'(1);
      end
      RUN: begin
        ready = 1'b1;
      end
      default: begin
        state_nx = BOOT;
      end
    endcase
  end

  // Boot image word for the current pointer, zero past BOOT_LEN.
  always_comb begin
    boot_data = '0;
    if (32'(boot_addr) < BOOT_LEN)
      boot_data = DATA_W'(boot_word(32'(boot_addr)));
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Instruction store with boot loader, enabled write port
// and one registered read port feeding decode.
module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned INS_W    = 5,
  parameter int unsigned BOOT_LEN = 8,
  parameter int unsigned RDW_NEW  = 0
) (
  input  logic              clk,
  input  logic              start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] data,
  output logic [INS_W-1:0]  ins,
  output logic              ins_valid,
  output logic              ready,
  output logic [ADDR_W-1:0] boot_addr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              boot_we;
  logic [DATA_W-1:0] boot_data;
  logic              run;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              bypass;
  logic [INS_W-1:0]  rd_ins;

  imem_boot_seq #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BOOT_LEN (BOOT_LEN)
  ) u_seq (
    .clk       (clk),
    .start     (start),
    .boot_we   (boot_we),
    .boot_addr (boot_addr),
    .boot_data (boot_data),
    .ready     (ready)
  );

  assign run = ready & ~start;

  // Write mux: the sequencer owns the array until ready.
  always_comb begin
    wr_en   = boot_we | (run & we);
    wr_addr = w_addr;
    wr_data = data;
    if (boot_we) begin
      wr_addr = boot_addr;
      wr_data = boot_data;
    end
  end

  // Read data, optionally forwarding a same-address write.
  always_comb begin
    bypass = (RDW_NEW != 0) && we && (w_addr == r_addr);
    rd_ins = mem[r_addr][INS_W-1:0];
    if (bypass)
      rd_ins = data[INS_W-1:0];
  end

  // Array write port; contents are rebuilt by the boot walk.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // Read register: holds on idle, zero while booting.
  always_ff @(posedge clk) begin
    if (start) begin
      ins       <= '0;
      ins_valid <= 1'b0;
    end else if (run && rd_en) begin
      ins       <= rd_ins;
      ins_valid <= 1'b1;
    end else if (!ready) begin
      ins       <= '0;
      ins_valid <= 1'b0;
    end else begin
      ins_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: both RDW modes side by side,
// checked each cycle against a boot-image/array model.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        start = 1'b1;
  logic        rd_en = 1'b0;
  logic [3:0]  r_addr = '0;
  logic        we = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [15:0] data = '0;

  logic [4:0]  ins0, ins1;
  logic        val0, val1;
  logic        rdy0, rdy1;
  logic [3:0]  ba0, ba1;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] mdl_mem [16];
  int          left = 16;
  logic [4:0]  e_ins0 = '0;
  logic [4:0]  e_ins1 = '0;
  logic        e_val = 1'b0;
  int          tbl [8] = '{1, 6, 4, 1, 4, 6, 1, 6};

  always #5 clk = ~clk;

  imem_boot_ctrl #(.RDW_NEW(0)) u0 (
    .clk(clk), .start(start), .rd_en(rd_en),
    .r_addr(r_addr), .we(we), .w_addr(w_addr),
    .data(data), .ins(ins0), .ins_valid(val0),
    .ready(rdy0), .boot_addr(ba0)
  );

  imem_boot_ctrl #(.RDW_NEW(1)) u1 (
    .clk(clk), .start(start), .rd_en(rd_en),
    .r_addr(r_addr), .we(we), .w_addr(w_addr),
    .data(data), .ins(ins1), .ins_valid(val1),
    .ready(rdy1), .boot_addr(ba1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic s, input logic re,
                     input logic [3:0] ra, input logic w,
                     input logic [3:0] wa,
                     input logic [15:0] d);
    logic [15:0] old;
    start = s; rd_en = re; r_addr = ra;
    we = w; w_addr = wa; data = d;
    @(posedge clk);
    if (s) begin
      left = 16; e_ins0 = '0; e_ins1 = '0; e_val = 1'b0;
    end else if (left > 0) begin
      left--;
      e_val = 1'b0;
      if (left == 0)
        for (int i = 0; i < 16; i++)
          mdl_mem[i] = (i < 8) ? 16'(tbl[i]) : 16'd0;
    end else begin
      e_val = re;
      if (re) begin
        old = mdl_mem[ra];
        e_ins0 = old[4:0];
        e_ins1 = (w && wa == ra) ? d[4:0] : old[4:0];
      end
      if (w) mdl_mem[wa] = d;
    end
    #1;
    chk("ready0", 32'(rdy0), 32'(left == 0));
    chk("ready1", 32'(rdy1), 32'(left == 0));
    chk("valid0", 32'(val0), 32'(e_val));
    chk("valid1", 32'(val1), 32'(e_val));
    chk("ins0", 32'(ins0), 32'(e_ins0));
    chk("ins1", 32'(ins1), 32'(e_ins1));
    chk("boot_addr", 32'(ba0),
        (left > 0) ? 32'(16 - left) : 32'd15);
    chk("boot_addr1", 32'(ba1), 32'(ba0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'd0);
  endtask

  task automatic rd(input logic [3:0] a);
    cyc(1'b0, 1'b1, a, 1'b0, 4'd0, 16'd0);
  endtask

  initial begin
    #1;
    // Reset and boot, then read back the whole image.
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 16'd0);
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 16'd0);
    idle(16);
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(1);

    // Write then read, upper bits dropped.
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 16'hFFF2);
    rd(4'd3);

    // Read during write to the same address, then reread.
    cyc(1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 16'h0013);
    rd(4'd5);

    // Independent read and write.
    cyc(1'b0, 1'b1, 4'd6, 1'b1, 4'd9, 16'h00AB);
    rd(4'd9);

    // Hold on rd_en=0 after a read returning 6.
    rd(4'd1);
    idle(3);

    // Accesses during boot are ignored.
    cyc(1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 16'h001F);
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 16'h001F);
    rd(4'd0);

    // Mid-boot restart after a RUN write to address 2.
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 4'd2, 16'h0009);
    rd(4'd2);
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 16'd0);
    idle(6);
    chk("mid_ba6", 32'(ba0), 32'd6);
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 16'd0);
    idle(16);
    rd(4'd2);

    // Random traffic with occasional restarts.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ra, wa;
      ra = ($urandom_range(0, 1) != 0) ?
           4'($urandom_range(4, 7)) : 4'($urandom_range(0, 15));
      wa = ($urandom_range(0, 1) != 0) ?
           4'($urandom_range(4, 7)) : 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 99) == 0),
          1'($urandom_range(0, 1)), ra,
          1'($urandom_range(0, 1)), wa,
          16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Parametrised successor to the single-port instruction/data store: a synchronous memory, DEPTH words by DATA_W bits, with one registered read port and one enabled write port.
- After reset, a boot sequencer copies a fixed boot program into the array, one word per cycle, and zero-fills the remaining words.
- Sits between the program loader/datapath write-back and the decode stage.
- Decode sees an INS_W-bit instruction field plus a valid flag.

Parameters:
- DATA_W, 16: stored word width.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W.
- INS_W, 5: width of the instruction field returned (the LSBs of the word); 1 <= INS_W <= DATA_W.
- BOOT_LEN, 8: number of words taken from the boot table; BOOT_LEN <= DEPTH.
- RDW_NEW, 0: read-during-write to the same address. 0 returns the old word; 1 returns the newly written word.

Ports:
- clk  in  1  rising-edge clock.
- start  in  1  synchronous active-high reset; also triggers a boot load.
- rd_en  in  1  read request.
- r_addr  in  ADDR_W  read address.
- we  in  1  write enable.
- w_addr  in  ADDR_W  write address.
- data  in  DATA_W  write data.
- ins  out  INS_W  registered instruction field, word[INS_W-1:0].
- ins_valid  out  1  ins was updated this cycle.
- ready  out  1  boot complete; access is accepted.
- boot_addr  out  ADDR_W  current boot pointer, for debug.

Behaviour:
- Clock is clk. Reset is start: synchronous, active-high. All state is sampled on the rising edge of clk.
- Reset values while start=1: ins=0, ins_valid=0, ready=0, boot_addr=0, FSM=BOOT. Array contents are not cleared directly by reset; the BOOT state rewrites every word.
- FSM states:
  - BOOT: each cycle writes M[boot_addr] = (boot_addr < BOOT_LEN) ? boot_word(boot_addr) : 0, then increments boot_addr. When boot_addr == DEPTH-1 is written, go to RUN. BOOT therefore takes exactly DEPTH cycles.
  - RUN: ready=1 from the first RUN cycle. Stays in RUN until start.
- start asserted in any state, including mid-BOOT, restarts BOOT at address 0. Outputs return to their reset values the following cycle.
- While in BOOT:
  - rd_en and we are ignored; no array write comes from the data port.
  - ins holds 0 and ins_valid=0.
- Read, in RUN:
  - rd_en=1 at edge N gives ins = M[r_addr][INS_W-1:0] and ins_valid=1 after edge N. Latency is 1 cycle.
  - rd_en=0 keeps ins at its last value and drives ins_valid=0.
- Write, in RUN: we=1 gives M[w_addr] = data at the edge. A write with we=0 never happens; this differs from the previous block, which wrote every cycle.
- Read and write on the same edge with r_addr == w_addr:
  - RDW_NEW=0: ins takes the pre-write word.
  - RDW_NEW=1: ins takes data[INS_W-1:0].
- Read and write on different addresses proceed independently.
- Address wrap: addresses are ADDR_W bits, so there is no out-of-range case. boot_addr does not wrap past DEPTH-1; the FSM leaves BOOT.
- The first read is possible on the cycle ready=1 is first seen.

Decomposition:
- Package imem_pkg holds:
  - state enum {BOOT, RUN};
  - the default boot table 1,6,4,1,4,6,1,6;
  - a boot_word(idx) function returning a 16-bit entry, zero-extended or truncated to DATA_W.
- Sub-module imem_boot_seq holds the FSM and boot_addr counter, and outputs boot_we, boot_addr, boot_data and ready.
- Top-level holds the array, the write mux (boot vs. port), and the read register with RDW logic.

Test Plan:
- Boot and readback: pulse start for 1 cycle, then wait.
  - ready rises exactly DEPTH=16 cycles after start deasserts.
  - Reading addresses 0..7 gives ins = 1,6,4,1,4,6,1,6, each with ins_valid one cycle after rd_en.
  - Reading addresses 8..15 gives ins = 0.
- Write then read: we=1, w_addr=3, data=16'hFFF2, then rd_en at r_addr=3 → ins=5'h12. Data bits above INS_W are dropped.
- Read-during-write to address 5, data=16'h0013:
  - RDW_NEW=0 → ins=6.
  - RDW_NEW=1 → ins=5'h13.
  - A following read of address 5 → ins=5'h13 in both modes.
- Access during boot: we=1 and rd_en=1 driven throughout BOOT with w_addr=0, data=16'h1F → ins_valid stays 0. After ready=1, address 0 reads 1.
- Mid-boot reset: assert start when boot_addr=6 after RUN had written address 2 = 16'h0009.
  - boot_addr returns to 0 and ready=0.
  - After 16 further cycles ready=1 and address 2 reads 4, the boot value.
- rd_en=0 hold: after a read returning 6, drop rd_en for 3 cycles → ins stays 6 and ins_valid=0.
